// File: rtl/mac_pkg.sv
// mac_pkg: shared encodings for the MAC job sequencer slice.
// Precision modes, FSM states, status bit positions, engine result widths.
package mac_pkg;

    localparam logic [3:0] MODE_2B = 4'd0;
    localparam logic [3:0] MODE_4B = 4'd1;
    localparam logic [3:0] MODE_8B = 4'd2;

    localparam int SUM_W  = 48;
    localparam int PROD_W = 32;

    localparam int ST_ILLEGAL_BIT = 0;
    localparam int ST_TIMEOUT_BIT = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_OUT
    } state_t;

    function automatic logic mode_legal(input logic [3:0] m);
        return (m == MODE_2B) || (m == MODE_4B) || (m == MODE_8B);
    endfunction

endpackage

// File: rtl/mac_job_sequencer_if.sv
// mac_job_sequencer_if: job descriptor and result handshakes.
// master = job producer / result consumer, slave = the sequencer.
interface mac_job_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    import mac_pkg::*;

    logic              job_valid;
    logic              job_ready;
    logic [3:0]        job_mode;
    logic [7:0]        job_len;
    logic [ADDR_W-1:0] job_abase;
    logic [ADDR_W-1:0] job_wbase;

    logic              res_valid;
    logic              res_ready;
    logic [SUM_W-1:0]  res_sum;
    logic [PROD_W-1:0] res_product;
    logic [1:0]        res_status;

    modport master (
        output job_valid, job_mode, job_len, job_abase, job_wbase,
        input  job_ready,
        input  res_valid, res_sum, res_product, res_status,
        output res_ready
    );

    modport slave (
        input  job_valid, job_mode, job_len, job_abase, job_wbase,
        output job_ready,
        output res_valid, res_sum, res_product, res_status,
        input  res_ready
    );

endinterface

// File: rtl/mac_operand_fetch.sv
// mac_operand_fetch: streams len operand-pair reads from base addresses.
// Ports: start/abase/wbase/len in, read strobes/addresses out, gated operands and last-read flag out.
module mac_operand_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] abase,
    input  logic [ADDR_W-1:0] wbase,
    input  logic [7:0]        len,
    output logic              act_rd,
    output logic              wgt_rd,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [7:0]        act_rdata,
    input  logic [7:0]        wgt_rdata,
    output logic [7:0]        activations,
    output logic [7:0]        weights,
    output logic              last
);

    logic              active;
    logic              dv;
    logic [7:0]        k;
    logic [7:0]        len_q;
    logic [ADDR_W-1:0] abase_q;
    logic [ADDR_W-1:0] wbase_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            active  <= 1'b0;
            dv      <= 1'b0;
            k       <= '0;
            len_q   <= '0;
            abase_q <= '0;
            wbase_q <= '0;
        end else begin
            // memory data is valid exactly one cycle after its strobe
            dv <= active;
            if (start) begin
                active  <= 1'b1;
                k       <= '0;
                len_q   <= len;
                abase_q <= abase;
                wbase_q <= wbase;
            end else if (active) begin
                k <= k + 8'd1;
                if (last) active <= 1'b0;
            end
        end
    end

    assign last     = active && (k == len_q - 8'd1);
    assign act_rd   = active;
    assign wgt_rd   = active;
    // address arithmetic wraps naturally at ADDR_W bits
    assign act_addr = active ? abase_q + ADDR_W'(k) : '0;
    assign wgt_addr = active ? wbase_q + ADDR_W'(k) : '0;

    assign activations = dv ? act_rdata : '0;
    assign weights     = dv ? wgt_rdata : '0;

endmodule

// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer: job FSM in front of the MAC engine with drain watchdog.
// Ports: host (job/result handshakes), operand memory reads, engine control/result, busy.
module mac_job_sequencer
    import mac_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              nrst,
    mac_job_sequencer_if.slave host,
    output logic              act_rd,
    output logic              wgt_rd,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [7:0]        act_rdata,
    input  logic [7:0]        wgt_rdata,
    output logic              eng_en,
    output logic [3:0]        eng_mode,
    output logic [7:0]        eng_batch_size,
    output logic [7:0]        eng_activations,
    output logic [7:0]        eng_weights,
    input  logic              eng_valid,
    output logic              eng_ready,
    input  logic [SUM_W-1:0]  eng_sum,
    input  logic [PROD_W-1:0] eng_product,
    output logic              busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic              rdy_q;
    logic [WD_W-1:0]   wd;
    logic [3:0]        mode_q;
    logic [7:0]        bs_q;
    logic [SUM_W-1:0]  sum_q;
    logic [PROD_W-1:0] prod_q;
    logic [1:0]        status_q;

    logic accept, start, last, wd_hit, capture, abort;

    mac_operand_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .abase       (host.job_abase),
        .wbase       (host.job_wbase),
        .len         (host.job_len),
        .act_rd      (act_rd),
        .wgt_rd      (wgt_rd),
        .act_addr    (act_addr),
        .wgt_addr    (wgt_addr),
        .act_rdata   (act_rdata),
        .wgt_rdata   (wgt_rdata),
        .activations (eng_activations),
        .weights     (eng_weights),
        .last        (last)
    );

    // last DRAIN cycle before abort; an eng_valid here loses to the timeout
    assign wd_hit    = (wd == WD_W'(TIMEOUT - 1));
    assign eng_ready = (state == S_DRAIN) && eng_valid && !wd_hit;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        start    = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (host.job_valid && rdy_q) begin
                    accept = 1'b1;
                    if (!mode_legal(host.job_mode) || host.job_len == 8'd0) begin
                        state_nx = S_OUT;
                    end else begin
                        start    = 1'b1;
                        state_nx = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (wd_hit) begin
                    abort    = 1'b1;
                    state_nx = S_OUT;
                end else if (eng_valid) begin
                    capture  = 1'b1;
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (host.res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rdy_q    <= 1'b0;
            wd       <= '0;
            mode_q   <= '0;
            bs_q     <= '0;
            sum_q    <= '0;
            prod_q   <= '0;
            status_q <= '0;
        end else begin
            // holds job_ready low through the reset cycle itself
            rdy_q <= 1'b1;
            if (state == S_DRAIN) wd <= wd + WD_W'(1);
            else                  wd <= '0;
            if (accept) begin
                mode_q   <= host.job_mode;
                bs_q     <= host.job_len;
                sum_q    <= '0;
                prod_q   <= '0;
                status_q <= '0;
                status_q[ST_ILLEGAL_BIT] <= !mode_legal(host.job_mode);
            end
            if (capture) begin
                sum_q    <= eng_sum;
                prod_q   <= eng_product;
                status_q <= '0;
            end
            if (abort) begin
                sum_q    <= '0;
                prod_q   <= '0;
                status_q <= '0;
                status_q[ST_TIMEOUT_BIT] <= 1'b1;
            end
        end
    end

    assign host.job_ready   = (state == S_IDLE) && rdy_q;
    assign host.res_valid   = (state == S_OUT);
    assign host.res_sum     = sum_q;
    assign host.res_product = prod_q;
    assign host.res_status  = status_q;

    assign eng_en         = (state == S_STREAM) || (state == S_DRAIN);
    assign eng_mode       = mode_q;
    assign eng_batch_size = bs_q;
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb_mac_job_sequencer: table, random and hand-sequence checks of mac_job_sequencer.
// Memories and engine are behavioural; expectations come from a per-job reference model.
module tb_mac_job_sequencer;
    import mac_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 15;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mac_job_sequencer_if #(.ADDR_W(ADDR_W)) host ();

    logic        act_rd, wgt_rd;
    logic [7:0]  act_addr, wgt_addr;
    logic [7:0]  act_rdata = 8'h0, wgt_rdata = 8'h0;
    logic        eng_en;
    logic [3:0]  eng_mode;
    logic [7:0]  eng_batch_size, eng_activations, eng_weights;
    logic        eng_valid, eng_ready;
    logic [47:0] eng_sum;
    logic [31:0] eng_product;
    logic        busy;

    mac_job_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .host            (host),
        .act_rd          (act_rd),
        .wgt_rd          (wgt_rd),
        .act_addr        (act_addr),
        .wgt_addr        (wgt_addr),
        .act_rdata       (act_rdata),
        .wgt_rdata       (wgt_rdata),
        .eng_en          (eng_en),
        .eng_mode        (eng_mode),
        .eng_batch_size  (eng_batch_size),
        .eng_activations (eng_activations),
        .eng_weights     (eng_weights),
        .eng_valid       (eng_valid),
        .eng_ready       (eng_ready),
        .eng_sum         (eng_sum),
        .eng_product     (eng_product),
        .busy            (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    // operand memories, 1-cycle read latency, junk when not strobed
    logic [7:0] act_mem [256];
    logic [7:0] wgt_mem [256];

    always @(posedge clk) begin
        act_rdata <= act_rd ? act_mem[act_addr] : 8'hA5;
        wgt_rdata <= wgt_rd ? wgt_mem[wgt_addr] : 8'h5A;
    end

    // engine: accumulates while enabled, raises valid cur_lat cycles into drain
    int          cur_len = 0;
    int          cur_lat = NEVER;
    int          e_idx   = 0;
    logic        e_valid = 1'b0;
    logic        force_valid = 1'b0;
    logic [47:0] e_acc  = '0;
    logic [31:0] e_prod = '0;

    always @(posedge clk) begin
        if (eng_en !== 1'b1) begin
            e_idx   <= 0;
            e_valid <= 1'b0;
            e_acc   <= '0;
            e_prod  <= '0;
        end else begin
            e_idx <= e_idx + 1;
            e_acc <= e_acc + 48'(eng_activations) * 48'(eng_weights);
            if (e_idx >= 1 && e_idx <= cur_len)
                e_prod <= 32'(eng_activations) * 32'(eng_weights);
            if (e_valid && eng_ready)
                e_valid <= 1'b0;
            else if (e_idx == cur_len + cur_lat - 1)
                e_valid <= 1'b1;
        end
    end

    assign eng_valid   = e_valid | force_valid;
    assign eng_sum     = e_acc;
    assign eng_product = e_prod;

    typedef struct {
        logic [47:0] sum;
        logic [31:0] prod;
        logic [1:0]  st;
        int          lat;
        bit          cap;
    } exp_t;

    // job-level reference: result from memory contents and the engine latency
    function automatic exp_t model(input int mode, input int len, input int ab,
                                   input int wb, input int lat);
        exp_t e;
        int p;
        e.sum = '0; e.prod = '0; e.cap = 1'b0; e.st = 2'b00; e.lat = 1;
        if (mode > 2) begin
            e.st = 2'b01;
        end else if (len == 0) begin
            e.st = 2'b00;
        end else if (lat >= 1 && lat <= TIMEOUT - 2) begin
            e.cap = 1'b1;
            e.lat = len + lat + 2;
            for (int k = 0; k < len; k++) begin
                p = int'(act_mem[(ab + k) % 256]) * int'(wgt_mem[(wb + k) % 256]);
                e.sum  = e.sum + 48'(p);
                e.prod = 32'(p);
            end
        end else begin
            e.st  = 2'b10;
            e.lat = len + TIMEOUT + 1;
        end
        return e;
    endfunction

    logic [47:0] last_sum;

    task automatic run_job(input string nm, input int mode, input int len, input int ab,
                           input int wb, input int lat, input int hold,
                           input logic [1:0] st_exp, input int lat_exp);
        exp_t e;
        bit legal;
        int c, s_err, o_err, en_err, stab_err, rdy_cnt, rdy_at, want_a, want_w;
        logic [47:0] s0;
        logic [31:0] p0;
        logic [1:0]  t0;
        e = model(mode, len, ab, wb, lat);
        legal = (mode <= 2) && (len > 0);
        s_err = 0; o_err = 0; en_err = 0; stab_err = 0; rdy_cnt = 0; rdy_at = -1;
        @(negedge clk);
        chk({nm, "/job_ready"}, host.job_ready, 1);
        host.job_mode  = 4'(mode);
        host.job_len   = 8'(len);
        host.job_abase = 8'(ab);
        host.job_wbase = 8'(wb);
        host.job_valid = 1'b1;
        cur_len = len;
        cur_lat = lat;
        @(posedge clk); #1;
        host.job_valid = 1'b0;
        chk({nm, "/eng_mode"}, eng_mode, 64'(mode));
        chk({nm, "/batch"}, eng_batch_size, 64'(len));
        for (c = 1; c <= 60; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (legal && c <= len) begin
                if (!(act_rd === 1'b1 && wgt_rd === 1'b1 &&
                      act_addr === 8'(ab + c - 1) && wgt_addr === 8'(wb + c - 1)))
                    s_err++;
            end else if (act_rd !== 1'b0 || wgt_rd !== 1'b0) begin
                s_err++;
            end
            want_a = (legal && c >= 2 && c <= len + 1) ? int'(act_mem[(ab + c - 2) % 256]) : 0;
            want_w = (legal && c >= 2 && c <= len + 1) ? int'(wgt_mem[(wb + c - 2) % 256]) : 0;
            if (eng_activations !== 8'(want_a) || eng_weights !== 8'(want_w)) o_err++;
            if (eng_en !== (legal && c < lat_exp) || busy !== 1'b1) en_err++;
            if (eng_ready === 1'b1) begin rdy_cnt++; rdy_at = c; end
            if (host.res_valid === 1'b1) break;
        end
        chk({nm, "/res_latency"}, 64'(c), 64'(lat_exp));
        chk({nm, "/strobes"}, 64'(s_err), 0);
        chk({nm, "/operands"}, 64'(o_err), 0);
        chk({nm, "/eng_en"}, 64'(en_err), 0);
        chk({nm, "/eng_ready_cnt"}, 64'(rdy_cnt), 64'(e.cap));
        chk({nm, "/eng_ready_at"}, 64'(rdy_at), e.cap ? 64'(len + lat + 1) : 64'(-1));
        chk({nm, "/res_sum"}, host.res_sum, e.sum);
        chk({nm, "/res_product"}, host.res_product, e.prod);
        chk({nm, "/res_status"}, host.res_status, st_exp);
        last_sum = host.res_sum;
        s0 = host.res_sum; p0 = host.res_product; t0 = host.res_status;
        repeat (hold) begin
            @(posedge clk); #1;
            if (host.res_valid !== 1'b1 || host.res_sum !== s0 || host.res_product !== p0 ||
                host.res_status !== t0 || eng_en !== 1'b0)
                stab_err++;
        end
        chk({nm, "/res_stable"}, 64'(stab_err), 0);
        host.res_ready = 1'b1;
        @(posedge clk); #1;
        host.res_ready = 1'b0;
        chk({nm, "/released"}, {host.res_valid, busy, host.job_ready}, 3'b001);
    endtask

    typedef struct {
        int         mode;
        int         len;
        int         ab;
        int         wb;
        int         lat;
        int         hold;
        logic [1:0] st;
        int         lat_exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        exp_t e;
        int   mode, len, lat, ab, wb, hold, seen;

        host.job_valid = 1'b0; host.job_mode = '0; host.job_len = '0;
        host.job_abase = '0;   host.job_wbase = '0; host.res_ready = 1'b0;

        for (int i = 0; i < 256; i++) begin
            act_mem[i] = 8'($urandom);
            wgt_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            act_mem[16 + i] = 8'(i + 1);
            wgt_mem[32 + i] = 8'(i + 5);
        end

        tbl[0] = '{2, 4, 'h10, 'h20, 2,     0, 2'b00, 8};
        tbl[1] = '{5, 3, 'h40, 'h50, 2,     0, 2'b01, 1};
        tbl[2] = '{1, 0, 'h00, 'h00, 2,     0, 2'b00, 1};
        tbl[3] = '{2, 3, 'h30, 'h40, NEVER, 0, 2'b10, 12};
        tbl[4] = '{0, 5, 'h50, 'h60, 3,     5, 2'b00, 10};
        tbl[5] = '{1, 4, 'hFE, 'hFC, 1,     0, 2'b00, 7};
        tbl[6] = '{2, 2, 'h70, 'h90, 7,     0, 2'b10, 11};
        tbl[7] = '{2, 1, 'h77, 'h99, 6,     0, 2'b00, 9};

        // reset: everything low, including job_ready in the reset cycle
        repeat (3) @(posedge clk);
        #1;
        chk("reset/ctrl", {host.job_ready, busy, host.res_valid, eng_en, act_rd, wgt_rd, eng_ready}, 0);
        chk("reset/data", {host.res_sum, host.res_status, eng_mode, eng_batch_size}, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("release/job_ready", host.job_ready, 1);

        // engine valid while idle is ignored
        @(negedge clk);
        force_valid = 1'b1;
        #1;
        chk("idle_valid/eng_ready", eng_ready, 0);
        @(posedge clk); #1;
        chk("idle_valid/state", {busy, host.res_valid}, 0);
        force_valid = 1'b0;

        foreach (tbl[i]) begin
            run_job($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].len, tbl[i].ab, tbl[i].wb,
                    tbl[i].lat, tbl[i].hold, tbl[i].st, tbl[i].lat_exp);
            if (i == 0) chk("tbl0/sum70", last_sum, 70);
        end

        for (int i = 0; i < 20; i++) begin
            mode = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 15);
            len  = $urandom_range(0, 12);
            lat  = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(1, 8);
            ab   = $urandom_range(0, 255);
            wb   = $urandom_range(0, 255);
            hold = $urandom_range(0, 3);
            e = model(mode, len, ab, wb, lat);
            run_job($sformatf("rnd%0d", i), mode, len, ab, wb, lat, hold, e.st, e.lat);
        end

        // reset in the middle of a streaming job
        @(negedge clk);
        host.job_mode = 4'd2; host.job_len = 8'd10;
        host.job_abase = 8'h80; host.job_wbase = 8'hC0;
        host.job_valid = 1'b1;
        cur_len = 10; cur_lat = 2;
        @(posedge clk); #1;
        host.job_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midjob/streaming", {act_rd, eng_en, busy}, 3'b111);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk); #1;
        chk("midjob/ctrl", {host.job_ready, busy, host.res_valid, eng_en, act_rd, wgt_rd, eng_ready}, 0);
        chk("midjob/data", {eng_activations, eng_weights, act_addr, wgt_addr, eng_mode,
                            eng_batch_size, host.res_status}, 0);
        chk("midjob/res", {host.res_sum, host.res_product}, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("midjob/job_ready", host.job_ready, 1);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (host.res_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("midjob/no_result", 64'(seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_job_sequencer.md
# mac_job_sequencer

Job-level controller that sits in front of the MAC engine. It accepts job descriptors (mode, length, operand base addresses) over a valid/ready port and streams activation/weight pairs from two 1-cycle-latency operand memories into the engine. It then completes the engine's valid/ready result handshake and presents the captured sum/product on a result port. A watchdog guards against a hung engine.

## Interface
- ADDR_W, 8, operand memory address width
- TIMEOUT, 1023, maximum cycles in DRAIN before abort (≥ 4)
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- job_valid  in  1  descriptor valid
- job_ready  out  1  sequencer can accept a descriptor
- job_mode  in  4  precision mode (0 = 2bx2b, 1 = 4bx4b, 2 = 8bx8b; others illegal)
- job_len  in  8  number of operand pairs
- job_abase / job_wbase  in  ADDR_W  activation / weight base address
- act_rd / wgt_rd  out  1  memory read strobes
- act_addr / wgt_addr  out  ADDR_W  read addresses
- act_rdata / wgt_rdata  in  8  read data, valid the cycle after the strobe
- eng_en  out  1  engine enable
- eng_mode  out  4  engine mode
- eng_batch_size  out  8  engine batch size
- eng_activations / eng_weights  out  8  operand pair
- eng_valid  in  1  engine result valid
- eng_ready  out  1  result accepted
- eng_sum  in  48  engine sum
- eng_product  in  32  engine product
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready
- res_sum  out  48  captured sum
- res_product  out  32  captured product
- res_status  out  2  bit0 = illegal mode, bit1 = timeout
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, STREAM, DRAIN, OUT.
- IDLE: job_ready = 1. On job_valid && job_ready:
  - latch the descriptor;
  - drive eng_mode = job_mode and eng_batch_size = job_len. Both hold until the next acceptance.
- Routing out of IDLE on acceptance:
  - illegal mode (> 2): go to OUT with res_sum = res_product = 0, res_status = 01. Engine and memories untouched.
  - job_len = 0: go to OUT with zero result, res_status = 00.
  - otherwise: go to STREAM.
- STREAM:
  - eng_en = 1.
  - Reads for pair k (k = 0..len-1) are issued on consecutive cycles, with act_addr = abase+k and wgt_addr = wbase+k. Addresses wrap modulo 2^ADDR_W.
  - Go to DRAIN after the last read.
- Operand path: eng_activations/eng_weights = act_rdata/wgt_rdata in the cycle after a read strobe, and 0 in all other cycles. No bubbles inside a job.
- DRAIN:
  - eng_en stays 1; operands are 0 after the final pair.
  - Watchdog counts cycles spent in DRAIN.
  - On eng_valid: eng_ready = 1 combinationally in that cycle; capture eng_sum/eng_product at that edge; res_status = 00; go to OUT.
  - Watchdog reaching TIMEOUT with no eng_valid: go to OUT with zero result, res_status = 10.
- OUT:
  - eng_en = 0 and res_valid = 1.
  - res_sum/res_product/res_status are stable while waiting.
  - On res_ready, go to IDLE.
- eng_ready is asserted only in DRAIN. An eng_valid seen in any other state is ignored.
- Mode and batch size never change while eng_en = 1.

## Timing
- Reset (nrst low at an edge): state = IDLE, and every output is 0 from the next cycle. This includes job_ready in the reset cycle.
- job_ready = 1 from the first cycle after release.
- Reset mid-job: abort immediately, no result produced, memory strobes drop next cycle.
- Acceptance at edge T gives the following cycle-by-cycle behaviour:
  - eng_en = 1 and the first read strobe occur in cycle T+1;
  - pair k appears on the engine inputs in cycle T+2+k;
  - the last strobe is in cycle T+len;
  - DRAIN begins in cycle T+len+1.
- eng_en is therefore high for at least one cycle before the first nonzero operand. The engine sees this as a cleared accumulator.
- Result capture to res_valid: 1 cycle.
- OUT→IDLE on res_ready; a new job can be accepted in the following cycle.
- eng_en is low for at least 1 cycle (OUT) between consecutive jobs.
- res_ready held high constantly: OUT lasts exactly 1 cycle.
- Watchdog is cleared on entry to DRAIN. At TIMEOUT exactly, abort is taken even if eng_valid arrives in that same cycle (timeout wins).

## Structure
- Shared package mac_pkg:
  - mode encodings MODE_2B/4B/8B;
  - state encoding;
  - status bit positions;
  - engine sum/product widths (48/32).
- One natural sub-module, mac_operand_fetch:
  - holds the address counters, the read strobes, the 1-cycle data-valid delay and operand zero gating;
  - takes start/base/len inputs and returns a last-read flag.
- FSM, watchdog and result registers stay in mac_job_sequencer.

## Test plan
- Mode 2, len 4, abase 0x10 holding 1,2,3,4, wbase 0x20 holding 5,6,7,8; engine model gives eng_valid with sum 70 → addresses 0x10–0x13 / 0x20–0x23 on consecutive cycles, eng_ready for 1 cycle, res_sum = 70, res_status = 00.
- Mode 5, len 3 → no memory strobes, eng_en stays 0, res_valid next cycle with res_status = 01 and zero result.
- Len 0, mode 1 → zero result, status 00, no engine activity.
- Engine model never asserts eng_valid, TIMEOUT = 8 → abort after 8 DRAIN cycles, res_status = 10, eng_en low in OUT.
- res_ready held low for 5 cycles, then pulsed → result stable throughout; back-to-back second job accepted the cycle after; eng_en low ≥ 1 cycle between jobs.
- abase = 0xFE, len 4 → addresses 0xFE, 0xFF, 0x00, 0x01; nrst pulsed in the middle of a second job → all outputs 0, no result, job_ready high after release.
